bmp_pixel_source: RTL and testbench
===================================

Name: bmp_pixel_source

Overview:
- Hardware replacement for the bench-side stimulus path. Reads a bottom-up BMP pixel array from a byte-wide synchronous-read frame memory and emits one 24-bit pixel per handshake.
- Pixels leave in row-major order, with hsync/vsync markers and x/y coordinates, ready to feed `top` and the location generator.
- Skips per-row BMP padding. Supports single-shot or continuous (repeating) frames.

Parameters:
- ADDR_WIDTH, 20, byte address width of the frame memory.
- DIM_WIDTH, 16, width of the width/height/x/y/frame fields.
- PIXEL_SIZE, 24, output pixel width (3 bytes, fixed).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begin a frame (ignored unless IDLE).
- continuous  in  1  sampled at start; 1 = restart automatically after the last pixel.
- base_addr  in  ADDR_WIDTH  byte address of the first pixel byte; sampled at start.
- width  in  DIM_WIDTH  pixels per row; sampled at start.
- height  in  DIM_WIDTH  rows per frame; sampled at start.
- padding  in  2  pad bytes per row (0..3); sampled at start.
- mem_rd  out  1  read strobe.
- mem_addr  out  ADDR_WIDTH  read address.
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd.
- out_ready  in  1  downstream accept (driven from `en`).
- out_valid  out  1  pixel valid.
- out_data  out  PIXEL_SIZE  {byte2, byte1, byte0}, byte0 at the lowest address.
- hsync  out  1  qualifies out_valid; first pixel of each row.
- vsync  out  1  qualifies out_valid; first pixel of the frame.
- x, y  out  DIM_WIDTH  coordinates of the current pixel.
- frame  out  DIM_WIDTH  completed-frame count; wraps at 2^DIM_WIDTH.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset: every output is 0, including mem_addr, out_data, x, y and frame. State = IDLE. A reset mid-frame aborts the frame: no done pulse, frame is not incremented.
- States: IDLE, RD0, RD1, RD2, CAP, EMIT, FIN.
- IDLE:
  - on start with width == 0 or height == 0, go to FIN (done pulses, no pixels emitted).
  - otherwise latch the configuration, set row_base = cur = base_addr and x = y = 0, then go to RD0.
- RD0: mem_rd = 1, mem_addr = cur.
- RD1: capture byte0; read cur+1.
- RD2: capture byte1; read cur+2.
- CAP: capture byte2; go to EMIT.
- EMIT:
  - out_valid = 1, with out_data, x, y, hsync and vsync held stable until out_ready.
  - hsync = (x == 0); vsync = (x == 0 && y == 0).
  - on acceptance (out_valid && out_ready), advance position:
    - x < width-1: x++, cur += 3.
    - else, y < height-1: x = 0, y++, row_base += width*3 + padding, cur = new row_base.
    - else: go to FIN.
  - otherwise go to RD0.
- FIN:
  - done = 1 for exactly one cycle; frame++ (not incremented for the zero-size case).
  - if continuous: restart from the latched base_addr, going to RD0 the next cycle with x = y = 0.
  - otherwise go to IDLE.
- Latency: start to first out_valid = 5 cycles (IDLE→RD0→RD1→RD2→CAP→EMIT). Steady throughput is 1 pixel per 5 cycles with out_ready held high.
- out_valid never drops without acceptance. mem_rd is never asserted outside RD0–RD2.
- start outside IDLE is ignored. continuous is latched at start; changing it mid-frame has no effect.
- Arithmetic: stride = width*3 + padding, computed in ADDR_WIDTH bits. Address wrap at 2^ADDR_WIDTH is silent.

Decomposition:
- detect_pkg (shared) holds:
  - state enum.
  - BYTES_PER_PIXEL = 3.
  - PIXEL_SIZE reuses the existing global define.
- One natural sub-module: bmp_addr_gen. It holds cur/row_base/x/y plus the advance logic, with inputs step and restart, and outputs last_pixel and the address. The FSM and byte assembly stay in the top level.

Test Plan:
- 2x2 frame, padding 2, base 0, out_ready = 1, memory bytes = index values:
  - pixels 0x020100 (x0,y0, hsync, vsync), 0x050403 (x1,y0), 0x0A0908 (x0,y1, hsync), 0x0D0C0B (x1,y1).
  - done pulses once; frame = 1.
- Same frame with out_ready low for 7 cycles at the second pixel: out_valid, out_data 0x050403, x = 1 all held stable; no extra mem_rd; total 4 pixels.
- start with width = 0, height = 5: done one cycle later, no out_valid, no mem_rd, frame stays 0.
- continuous = 1, 1x1 frame, base 0x10:
  - after the pixel at 0x10..0x12, done pulses and the next pixel is again 0x10..0x12 with vsync.
  - frame increments 1, 2, 3.
- reset_n low for 1 cycle mid-row of a 4x2 frame: all outputs 0 the next cycle, state IDLE, no done pulse. A new start then replays from pixel (0,0).
- start pulsed during EMIT of a 3x1 frame: ignored; exactly 3 pixels and a single done pulse.

Source files
------------

// File: rtl/detect_pkg.sv
// detect_pkg: shared FSM states and pixel geometry constants for the BMP pixel source.
package detect_pkg;
    localparam int BYTES_PER_PIXEL = 3;
    localparam int PIXEL_SIZE = 24;
    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, CAP, EMIT, FIN} state_t;
endpackage

// File: rtl/bmp_addr_gen.sv
// bmp_addr_gen: pixel position and byte address walker over a padded bottom-up BMP pixel array.
module bmp_addr_gen import detect_pkg::*; #(
    parameter int ADDR_WIDTH = 20,
    parameter int DIM_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  restart,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] restart_addr,
    input  logic [DIM_WIDTH-1:0]  width,
    input  logic [DIM_WIDTH-1:0]  height,
    input  logic [1:0]            padding,
    output logic [ADDR_WIDTH-1:0] cur,
    output logic [DIM_WIDTH-1:0]  x,
    output logic [DIM_WIDTH-1:0]  y,
    output logic                  last_pixel
);
    logic [ADDR_WIDTH-1:0] row_base, stride;
    logic x_last, y_last;
    assign stride = ADDR_WIDTH'(width) * ADDR_WIDTH'(BYTES_PER_PIXEL) + ADDR_WIDTH'(padding);
    assign x_last = x == width - DIM_WIDTH'(1);
    assign y_last = y == height - DIM_WIDTH'(1);
    assign last_pixel = x_last && y_last;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            row_base <= '0;
            cur      <= '0;
            x        <= '0;
            y        <= '0;
        end else if (restart) begin
            row_base <= restart_addr;
            cur      <= restart_addr;
            x        <= '0;
            y        <= '0;
        end else if (step) begin
            if (!x_last) begin
                x   <= x + DIM_WIDTH'(1);
                cur <= cur + ADDR_WIDTH'(BYTES_PER_PIXEL);
            end else begin
                x        <= '0;
                y        <= y + DIM_WIDTH'(1);
                row_base <= row_base + stride;
                cur      <= row_base + stride;
            end
        end
    end
endmodule

// File: rtl/bmp_pixel_source.sv
// bmp_pixel_source: streams 24-bit pixels from a byte-wide frame memory with row/frame markers.
module bmp_pixel_source import detect_pkg::*; #(
    parameter int ADDR_WIDTH = 20,
    parameter int DIM_WIDTH = 16,
    parameter int PIXEL_SIZE = detect_pkg::PIXEL_SIZE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [DIM_WIDTH-1:0]  width,
    input  logic [DIM_WIDTH-1:0]  height,
    input  logic [1:0]            padding,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_rdata,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [PIXEL_SIZE-1:0] out_data,
    output logic                  hsync,
    output logic                  vsync,
    output logic [DIM_WIDTH-1:0]  x,
    output logic [DIM_WIDTH-1:0]  y,
    output logic [DIM_WIDTH-1:0]  frame,
    output logic                  busy,
    output logic                  done
);
    state_t state, next;
    logic [ADDR_WIDTH-1:0] base_q, cur;
    logic [DIM_WIDTH-1:0]  w_q, h_q;
    logic [1:0]            pad_q;
    logic                  cont_q, zero_q, last_pixel, zero_size, restart, step;
    logic [7:0]            b0, b1;
    assign zero_size = width == '0 || height == '0;
    // the first start takes base_addr live; continuous restarts replay the latched copy
    assign restart = (state == IDLE && start && !zero_size) || (state == FIN && cont_q);
    assign step = state == EMIT && out_ready && !last_pixel;
    bmp_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DIM_WIDTH(DIM_WIDTH)) u_addr (
        .clk(clk), .reset_n(reset_n), .restart(restart), .step(step),
        .restart_addr(state == IDLE ? base_addr : base_q),
        .width(w_q), .height(h_q), .padding(pad_q),
        .cur(cur), .x(x), .y(y), .last_pixel(last_pixel)
    );
    always_ff @(posedge clk) state <= !reset_n ? IDLE : next;
    always_comb begin
        next = state;
        unique case (state)
            IDLE:    next = start ? (zero_size ? FIN : RD0) : IDLE;
            RD0:     next = RD1;
            RD1:     next = RD2;
            RD2:     next = CAP;
            CAP:     next = EMIT;
            EMIT:    next = out_ready ? (last_pixel ? FIN : RD0) : EMIT;
            FIN:     next = cont_q ? RD0 : IDLE;
            default: next = IDLE;
        endcase
    end
    assign mem_rd = state == RD0 || state == RD1 || state == RD2;
    assign mem_addr = state == RD0 ? cur :
                      state == RD1 ? cur + ADDR_WIDTH'(1) :
                      state == RD2 ? cur + ADDR_WIDTH'(2) : '0;
    assign out_valid = state == EMIT;
    assign hsync = out_valid && x == '0;
    assign vsync = hsync && y == '0;
    assign busy = state != IDLE;
    assign done = state == FIN;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            {base_q, w_q, h_q, pad_q, cont_q, zero_q, b0, b1} <= '0;
            out_data <= '0;
            frame    <= '0;
        end else begin
            if (state == IDLE && start) begin
                base_q <= base_addr;
                w_q    <= width;
                h_q    <= height;
                pad_q  <= padding;
                cont_q <= continuous && !zero_size;
                zero_q <= zero_size;
            end
            if (state == RD1) b0 <= mem_rdata;
            if (state == RD2) b1 <= mem_rdata;
            if (state == CAP) out_data <= {mem_rdata, b1, b0};
            if (state == FIN && !zero_q) frame <= frame + DIM_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_bmp_pixel_source.sv
// tb_bmp_pixel_source: directed checks of frame walk, stalls, zero size, continuous mode and resets.
module tb_bmp_pixel_source;
    logic        clk = 0, reset_n = 0, start = 0, continuous = 0, out_ready = 1;
    logic [19:0] base_addr = '0;
    logic [15:0] width = '0, height = '0;
    logic [1:0]  padding = '0;
    logic        mem_rd, out_valid, hsync, vsync, busy, done;
    logic [19:0] mem_addr;
    logic [7:0]  mem_rdata = '0;
    logic [23:0] out_data;
    logic [15:0] x, y, frame;
    logic [7:0]  mem [256];
    int total = 0, bad = 0, ndone = 0, nrd = 0, d0, r0, q0;
    logic [57:0] pq [$];

    bmp_pixel_source dut (
        .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous),
        .base_addr(base_addr), .width(width), .height(height), .padding(padding),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .hsync(hsync), .vsync(vsync), .x(x), .y(y), .frame(frame),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr[7:0]];
        if (out_valid && out_ready) pq.push_back({vsync, hsync, y, x, out_data});
        if (done) ndone <= ndone + 1;
        if (mem_rd) nrd <= nrd + 1;
    end

    function automatic logic [57:0] pix(input bit vs, input bit hs, input int yy, input int xx, input logic [23:0] d);
        return {vs, hs, 16'(yy), 16'(xx), d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_start(input int w, input int h, input int pad, input int base, input bit cont);
        width = 16'(w); height = 16'(h); padding = 2'(pad); base_addr = 20'(base); continuous = cont;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 200) begin tick(); n++; end
        chk(tag, done, 1);
    endtask

    task automatic wait_valid_x(input string tag, input int xt);
        int n = 0;
        while (!(out_valid && x == 16'(xt)) && n < 200) begin tick(); n++; end
        chk(tag, out_valid && x == 16'(xt), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, {out_valid, busy, mem_rd, done, hsync, vsync, mem_addr}, '0);
        chk({tag, "_data"}, {out_data, x}, '0);
        chk({tag, "_pos"}, {y, frame}, '0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        tick(); tick();
        chk_all_zero("reset");
        reset_n = 1;
        tick();

        // zero width: done one cycle after start, nothing read or emitted
        d0 = ndone; r0 = nrd; q0 = pq.size();
        do_start(0, 5, 0, 0, 0);
        chk("zero_done", {done, busy}, 2'b11);
        tick();
        chk("zero_idle", {done, busy}, 2'b00);
        chk("zero_ndone", ndone - d0, 1);
        chk("zero_nrd", nrd - r0, 0);
        chk("zero_npix", pq.size() - q0, 0);
        chk("zero_frame", frame, 0);

        // 2x2 frame, padding 2, free-running ready
        d0 = ndone; r0 = nrd; q0 = pq.size();
        do_start(2, 2, 2, 0, 0);
        chk("f1_rd0", {mem_rd, mem_addr}, {1'b1, 20'h0});
        tick(); tick(); tick();
        chk("f1_lat4", out_valid, 0);
        tick();
        chk("f1_lat5", {out_valid, hsync, vsync, out_data}, {3'b111, 24'h020100});
        wait_done("f1_done");
        tick();
        chk("f1_npix", pq.size() - q0, 4);
        chk("f1_p0", pq[q0], pix(1, 1, 0, 0, 24'h020100));
        chk("f1_p1", pq[q0 + 1], pix(0, 0, 0, 1, 24'h050403));
        chk("f1_p2", pq[q0 + 2], pix(0, 1, 1, 0, 24'h0A0908));
        chk("f1_p3", pq[q0 + 3], pix(0, 0, 1, 1, 24'h0D0C0B));
        chk("f1_ndone", ndone - d0, 1);
        chk("f1_nrd", nrd - r0, 12);
        chk("f1_frame", frame, 1);
        chk("f1_idle", busy, 0);

        // same frame with a 7-cycle stall on the second pixel
        q0 = pq.size();
        do_start(2, 2, 2, 0, 0);
        wait_valid_x("stall_reach", 1);
        out_ready = 0;
        r0 = nrd;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("stall_hold", {out_valid, out_data, x}, {1'b1, 24'h050403, 16'd1});
        end
        chk("stall_nrd", nrd - r0, 0);
        out_ready = 1;
        wait_done("stall_done");
        tick();
        chk("stall_npix", pq.size() - q0, 4);
        chk("stall_p1", pq[q0 + 1], pix(0, 0, 0, 1, 24'h050403));
        chk("stall_frame", frame, 2);

        // continuous 1x1 frame at 0x10; continuous dropped after start must not matter
        reset_n = 0; tick(); reset_n = 1; tick();
        d0 = ndone; q0 = pq.size();
        do_start(1, 1, 0, 'h10, 1);
        continuous = 0;
        for (int k = 1; k <= 3; k++) begin
            wait_done("cont_done");
            tick();
            chk("cont_frame", frame, k);
        end
        wait_valid_x("cont_again", 0);
        chk("cont_again_px", {vsync, out_data}, {1'b1, 24'h121110});
        chk("cont_ndone", ndone - d0, 3);
        for (int i = 0; i < 3; i++) chk("cont_pix", pq[q0 + i], pix(1, 1, 0, 0, 24'h121110));

        // reset mid-row of a 4x2 frame aborts silently
        reset_n = 0; tick(); reset_n = 1; tick();
        d0 = ndone;
        do_start(4, 2, 0, 0, 0);
        wait_valid_x("rst_reach", 2);
        reset_n = 0;
        tick();
        chk_all_zero("midreset");
        reset_n = 1;
        tick();
        chk("rst_nodone", ndone - d0, 0);
        q0 = pq.size();
        do_start(4, 2, 0, 0, 0);
        wait_valid_x("rst_first", 0);
        chk("rst_first_px", {vsync, y, out_data}, {1'b1, 16'd0, 24'h020100});
        wait_done("rst_done");
        tick();
        chk("rst_npix", pq.size() - q0, 8);
        chk("rst_p4", pq[q0 + 4], pix(0, 1, 1, 0, 24'h0E0D0C));
        chk("rst_p7", pq[q0 + 7], pix(0, 0, 1, 3, 24'h171615));
        chk("rst_frame", frame, 1);

        // start pulsed during EMIT of a 3x1 frame is ignored
        d0 = ndone; q0 = pq.size();
        do_start(3, 1, 1, 'h20, 0);
        chk("s_rd0", mem_addr, 'h20);
        tick();
        chk("s_rd1", {mem_rd, mem_addr}, {1'b1, 20'h21});
        tick();
        chk("s_rd2", {mem_rd, mem_addr}, {1'b1, 20'h22});
        wait_valid_x("s_emit", 0);
        start = 1; tick(); start = 0;
        wait_done("s_done");
        repeat (20) tick();
        chk("s_npix", pq.size() - q0, 3);
        chk("s_p2", pq[q0 + 2], pix(0, 0, 0, 2, 24'h282726));
        chk("s_ndone", ndone - d0, 1);
        chk("s_idle", {busy, mem_rd}, 2'b00);
        chk("s_frame", frame, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
